ram_4x4_ctrl: RTL and testbench

Command front-end that sits directly upstream of the 4x4 RAM and drives its en / R_W / address / data_in pins. It buffers read and write commands in a 4-entry FIFO and issues them to the RAM one at a time. It samples the RAM's combinational read data and returns it on a valid/ready response port. Client logic never touches RAM pins directly; the controller guarantees that en is pulsed for exactly one cycle per command.

---
 rtl/ram_4x4_ctrl_if.sv | 15 +
 rtl/ram_4x4_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_4x4_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ram_4x4_ctrl_if.sv
// ram_4x4_ctrl_if: client-side command/response bus of the RAM controller.
interface ram_4x4_ctrl_if #(parameter int DATA_W = 4, parameter int ADDR_W = 2);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  modport master (output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data);
  modport slave  (input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/ram_4x4_ctrl.sv
// ram_4x4_ctrl: FIFO-buffered command front-end driving a 4x4 RAM, one en pulse per command.
// Optional RAM_CTRL_INIT_EN zero-fills every RAM word after reset before accepting commands.
module ram_4x4_ctrl #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 2,
  parameter int CMD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_4x4_ctrl_if.slave     bus,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              idle
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;
`ifdef RAM_CTRL_INIT_EN
  typedef enum logic [1:0] {INIT, IDLE, ISSUE, RESP} state_t;
  localparam state_t RST_ST = INIT;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam state_t RST_ST = IDLE;
`endif
  state_t            state_q, state_d;
  logic [EW-1:0]     fifo_mem [CMD_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              ram_en_q, ram_en_d, ram_rw_q, ram_rw_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              full, push, pop, h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  assign full = count_q == (PW+1)'(CMD_DEPTH);
`ifdef RAM_CTRL_INIT_EN
  assign bus.cmd_ready = !full && state_q != INIT;
`else
  assign bus.cmd_ready = !full;
`endif
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = state_q == IDLE && count_q != '0;
  assign {h_we, h_addr, h_data} = fifo_mem[rd_ptr_q];
  assign ram_en        = ram_en_q;
  assign ram_rw        = ram_rw_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign idle          = state_q == IDLE && count_q == '0;
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
    state_d     = state_q;
    ram_en_d    = 1'b0;
    ram_rw_d    = ram_rw_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
`ifdef RAM_CTRL_INIT_EN
      INIT: begin
        // first INIT cycle is idle; then one zero-write per address, leaving after the top one
        ram_en_d   = !(ram_en_q && ram_addr_q == '1);
        ram_rw_d   = 1'b1;
        ram_din_d  = '0;
        ram_addr_d = ram_en_q ? ram_addr_q + ADDR_W'(1) : '0;
        state_d    = ram_en_d ? INIT : IDLE;
      end
`endif
      IDLE: if (pop) begin
        ram_en_d   = 1'b1;
        ram_rw_d   = h_we;
        ram_addr_d = h_addr;
        ram_din_d  = h_we ? h_data : '0;
        state_d    = ISSUE;
      end
      ISSUE: if (ram_rw_q) state_d = IDLE;
      else begin
        rsp_data_d  = ram_dout;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr_q] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= RST_ST;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
endmodule

// File: tb/tb_ram_4x4_ctrl.sv
// tb_ram_4x4_ctrl: directed + random bench for ram_4x4_ctrl with a behavioural RAM and reference model.
// Honours RAM_CTRL_INIT_EN for the reset-time zero-fill expectations.
module tb_ram_4x4_ctrl;
`ifdef RAM_CTRL_INIT_EN
  localparam logic INIT_ON = 1'b1;
`else
  localparam logic INIT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ram_4x4_ctrl_if #(.DATA_W(4), .ADDR_W(2)) bus ();
  logic       ram_en, ram_rw, idle;
  logic [1:0] ram_addr;
  logic [3:0] ram_din, ram_dout;
  ram_4x4_ctrl #(.DATA_W(4), .ADDR_W(2), .CMD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .ram_en(ram_en), .ram_rw(ram_rw),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .idle(idle)
  );
  // behavioural 4x4 RAM: combinational read while enabled for read, Z otherwise
  logic [3:0] ram_mem [4] = '{default: 4'hF};
  always @(posedge clk) if (ram_en && ram_rw) ram_mem[ram_addr] <= ram_din;
  assign ram_dout = (ram_en && !ram_rw) ? ram_mem[ram_addr] : 4'bz;
  int en_cnt = 0;
  always @(posedge clk) if (ram_en) en_cnt <= en_cnt + 1;
  logic [3:0] shadow [4] = '{default: 4'hF};
  logic [3:0] save [4];
  logic [3:0] exp_q [$];
  logic [3:0] hold;
  int tests = 0, fails = 0, cmd_acc = 0, en_off = 0, en_before = 0;
  logic last_acc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one cycle: settle response handshake against the model, offer a command, advance to next negedge
  task automatic step(input logic v, input logic we, input logic [1:0] a, input logic [3:0] d, input logic rr);
    bus.rsp_ready = rr;
    if (bus.rsp_valid && rr) begin
      chk("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("rsp_data", bus.rsp_data, exp_q.pop_front());
    end
    bus.cmd_valid = v;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    last_acc = v && bus.cmd_ready;
    if (last_acc) begin
      cmd_acc++;
      if (we) shadow[a] = d;
      else exp_q.push_back(shadow[a]);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic nop(input logic rr);
    step(1'b0, 1'b0, 2'd0, 4'd0, rr);
  endtask
  task automatic push(input logic we, input logic [1:0] a, input logic [3:0] d);
    int n = 0;
    do begin step(1'b1, we, a, d, 1'b1); n++; end while (!last_acc && n < 20);
    chk("push_accepted", last_acc, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(idle && !bus.rsp_valid && exp_q.size() == 0) && n < 200) begin nop(1'b1); n++; end
    chk("drain_in_time", n < 200, 1);
    chk("en_pulses", en_cnt - en_off, cmd_acc);
  endtask
  task automatic after_reset();
    int k = 0, n = 0;
`ifdef RAM_CTRL_INIT_EN
    while (!bus.cmd_ready && n < 20) begin
      if (ram_en) begin
        chk("init_addr", ram_addr, k);
        chk("init_rw", ram_rw, 1);
        chk("init_din", ram_din, 0);
        k++;
      end
      @(negedge clk);
      n++;
    end
    chk("init_writes", k, 4);
    for (int i = 0; i < 4; i++) shadow[i] = 4'h0;
`else
    @(negedge clk);
    chk("ready_after_reset", bus.cmd_ready, 1);
`endif
    en_off = en_cnt;
    cmd_acc = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_rw", ram_rw, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_cmd_ready", bus.cmd_ready, !INIT_ON);
    chk("rst_idle", idle, !INIT_ON);
    rst_n = 1'b1;
    after_reset();
`ifdef RAM_CTRL_INIT_EN
    push(1'b0, 2'd3, 4'd0);
    wait_idle();
`endif
    push(1'b1, 2'd2, 4'hA);
    wait_idle();
    step(1'b1, 1'b0, 2'd2, 4'h5, 1'b1);
    chk("lat_accept", last_acc, 1);
    chk("lat_e0_en", ram_en, 0);
    chk("lat_e0_vld", bus.rsp_valid, 0);
    nop(1'b1);
    chk("lat_e1_en", ram_en, 1);
    chk("lat_e1_rw", ram_rw, 0);
    chk("lat_e1_addr", ram_addr, 2);
    chk("lat_e1_din", ram_din, 0);
    chk("lat_e1_vld", bus.rsp_valid, 0);
    nop(1'b1);
    chk("lat_e2_vld", bus.rsp_valid, 1);
    chk("lat_e2_data", bus.rsp_data, 4'hA);
    chk("lat_e2_en", ram_en, 0);
    nop(1'b1);
    chk("lat_e3_vld", bus.rsp_valid, 0);
    wait_idle();
    step(1'b1, 1'b0, 2'd1, 4'd0, 1'b0);
    for (int n = 0; n < 10 && !bus.rsp_valid; n++) nop(1'b0);
    chk("stall_rsp_seen", bus.rsp_valid, 1);
    chk("stall_first_data", bus.rsp_data, exp_q[0]);
    hold = bus.rsp_data;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom), 2'($urandom), 4'($urandom), 1'b0);
      chk("stall_accept", last_acc, i < 4);
      chk("stall_vld", bus.rsp_valid, 1);
      chk("stall_hold", bus.rsp_data, hold);
      chk("stall_en", ram_en, 0);
    end
    nop(1'b1);
    chk("release_vld", bus.rsp_valid, 0);
    wait_idle();
    for (int i = 0; i < 4; i++) push(1'b1, 2'(i), 4'(i + 1));
    push(1'b0, 2'd3, 4'd0);
    push(1'b0, 2'd0, 4'd0);
    chk("seq_model_3", shadow[3], 4'h4);
    wait_idle();
    for (int i = 0; i < 80; i++)
      step(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    wait_idle();
    for (int i = 0; i < 4; i++) save[i] = shadow[i];
    step(1'b1, 1'b0, 2'd1, 4'd0, 1'b1);
    step(1'b1, 1'b1, 2'd1, ~shadow[1], 1'b1);
    chk("pre_rst_en", ram_en, 1);
    chk("pre_rst_rw", ram_rw, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_en", ram_en, 0);
    chk("rst_async_vld", bus.rsp_valid, 0);
    chk("rst_async_idle", idle, !INIT_ON);
    for (int i = 0; i < 4; i++) shadow[i] = save[i];
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    after_reset();
    en_before = en_cnt;
    repeat (5) nop(1'b1);
    chk("no_access_after_rst", en_cnt, en_before);
    chk("rsp_vld_after_rst", bus.rsp_valid, 0);
    push(1'b0, 2'd1, 4'd0);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
